// File: rtl/bin_to_bcd_seq_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
// Default sizing targets the eight-digit seven-segment display.
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int DEF_IN_W   = 27;
    localparam int DEF_DIGITS = 8;
    localparam int CNT_W      = $clog2(DEF_IN_W + 1);

    // Largest value representable in DEF_DIGITS decimal digits.
    localparam logic [63:0] BCD_MAX     = 64'd99_999_999;
    localparam logic [31:0] OVF_PATTERN = 32'hFFFF_FFFF;

endpackage

// File: rtl/bin_to_bcd_seq_nibble_adj.sv
// Double-dabble digit correction: a nibble of 5 or more gets +3 (mod 16)
// so that the following left shift carries correctly into the next digit.
module bcd_nibble_adj (
    input  logic [3:0] nib,
    output logic [3:0] adj
);

    always_comb begin
        adj = nib;
        if (nib >= 4'd5) begin
            adj = nib + 4'd3;
        end
    end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Iterative binary-to-packed-BCD converter with a start/done handshake.
// bcd/ovf change only on the done edge, so the display never sees partial results.
module bin_to_bcd_seq
    import bcd_pkg::*;
#(
    parameter int IN_W   = DEF_IN_W,
    parameter int DIGITS = DEF_DIGITS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [IN_W-1:0]       bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  ovf
);

    localparam int BW = 4 * DIGITS;
    localparam int CW = $clog2(IN_W + 1);

    state_t          state_reg, state_next;
    logic [CW-1:0]   cnt_reg, cnt_next;
    logic [IN_W-1:0] sr_reg, sr_next;
    logic [BW-1:0]   wb_reg, wb_next;
    logic            pend_reg, pend_next;
    logic [BW-1:0]   bcd_reg, bcd_next;
    logic            ovf_reg, ovf_next;
    logic            done_reg, done_next;
    logic [BW-1:0]   wb_adj;

    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_adj
            bcd_nibble_adj u_adj (
                .nib (wb_reg[gi*4 +: 4]),
                .adj (wb_adj[gi*4 +: 4])
            );
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            sr_reg    <= '0;
            wb_reg    <= '0;
            pend_reg  <= 1'b0;
            bcd_reg   <= '0;
            ovf_reg   <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            sr_reg    <= sr_next;
            wb_reg    <= wb_next;
            pend_reg  <= pend_next;
            bcd_reg   <= bcd_next;
            ovf_reg   <= ovf_next;
            done_reg  <= done_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        sr_next    = sr_reg;
        wb_next    = wb_reg;
        pend_next  = pend_reg;
        bcd_next   = bcd_reg;
        ovf_next   = ovf_reg;
        done_next  = 1'b0;

        case (state_reg)
            IDLE: begin
                if (start) begin
                    sr_next    = bin;
                    wb_next    = '0;
                    cnt_next   = CW'(IN_W);
                    pend_next  = (64'(bin) > BCD_MAX);
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                // The range check is registered at accept time; an
                // out-of-range operand spends this one cycle here and
                // skips the shifting entirely.
                if (pend_reg) begin
                    state_next = DONE;
                end else begin
                    {wb_next, sr_next} = {wb_adj[BW-2:0], sr_reg, 1'b0};
                    cnt_next = cnt_reg - CW'(1);
                    if (cnt_reg == CW'(1)) begin
                        state_next = DONE;
                    end
                end
            end
            DONE: begin
                done_next  = 1'b1;
                ovf_next   = pend_reg;
                bcd_next   = pend_reg ? BW'(OVF_PATTERN) : wb_reg;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign busy = (state_reg != IDLE);
    assign done = done_reg;
    assign bcd  = bcd_reg;
    assign ovf  = ovf_reg;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Randomised self-checking bench for bin_to_bcd_seq against a decimal-digit
// reference model built from plain integer division.
module tb_bin_to_bcd_seq;

    logic        clk;
    logic        rst;
    logic        start;
    logic [26:0] bin;
    logic        busy;
    logic        done;
    logic [31:0] bcd;
    logic        ovf;

    int tests_run    = 0;
    int tests_failed = 0;

    bin_to_bcd_seq dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .bcd   (bcd),
        .ovf   (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] ref_bcd(input int unsigned v);
        logic [31:0] r;
        int unsigned x;
        r = '0;
        if (v > 32'd99_999_999) return 32'hFFFF_FFFF;
        x = v;
        for (int i = 0; i < 8; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic int ref_lat(input int unsigned v);
        return (v > 32'd99_999_999) ? 2 : 28;
    endfunction

    // Drives one accepted start and waits for done; reports what was observed.
    task automatic do_conv(input logic [26:0] v, output int lat, output logic [31:0] ob,
                           output logic oo, output logic busy_seen);
        start = 1'b1;
        bin   = v;
        @(posedge clk); #1;
        start = 1'b0;
        bin   = 27'($urandom);
        busy_seen = busy;
        lat = -1;
        ob  = bcd;
        oo  = ovf;
        for (int c = 1; c <= 60; c++) begin
            @(posedge clk); #1;
            if (done) begin
                lat = c;
                ob  = bcd;
                oo  = ovf;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; start = 1'b0; bin = '0;
        repeat (3) @(posedge clk);
        #1;
        tests_run++;
        if ({busy, done, ovf, bcd} !== 35'd0) begin
            tests_failed++;
            $display("FAIL reset_state: busy=%b done=%b ovf=%b bcd=%h required all zero", busy, done, ovf, bcd);
        end
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_zero();
        int lat; logic [31:0] ob; logic oo, bs;
        do_conv(27'd0, lat, ob, oo, bs);
        $display("[TB] conv bin=0 lat=%0d bcd=%h ovf=%b", lat, ob, oo);
        tests_run++;
        if (bs !== 1'b1) begin tests_failed++; $display("FAIL zero_busy: busy=%b required 1", bs); end
        tests_run++;
        if (lat != 28) begin tests_failed++; $display("FAIL zero_latency: got %0d required 28", lat); end
        tests_run++;
        if (ob !== 32'h0 || oo !== 1'b0) begin tests_failed++; $display("FAIL zero_value: bcd=%h ovf=%b required 00000000/0", ob, oo); end
        @(posedge clk); #1;
        tests_run++;
        if (done !== 1'b0 || busy !== 1'b0) begin tests_failed++; $display("FAIL zero_after: done=%b busy=%b required 0/0", done, busy); end
    endtask

    task automatic test_known();
        int lat; logic [31:0] ob; logic oo, bs;
        do_conv(27'd12_345_678, lat, ob, oo, bs);
        $display("[TB] conv bin=12345678 lat=%0d bcd=%h ovf=%b", lat, ob, oo);
        tests_run++;
        if (ob !== 32'h1234_5678 || oo !== 1'b0 || lat != 28) begin
            tests_failed++;
            $display("FAIL known_12345678: bcd=%h ovf=%b lat=%0d required 12345678/0/28", ob, oo, lat);
        end
    endtask

    task automatic test_back_to_back();
        int lat; logic [31:0] ob; logic oo, bs;
        do_conv(27'd99_999_999, lat, ob, oo, bs);
        $display("[TB] conv bin=99999999 lat=%0d bcd=%h ovf=%b", lat, ob, oo);
        tests_run++;
        if (ob !== 32'h9999_9999 || oo !== 1'b0 || lat != 28) begin
            tests_failed++;
            $display("FAIL max_value: bcd=%h ovf=%b lat=%0d required 99999999/0/28", ob, oo, lat);
        end
        // Start immediately in the first IDLE cycle after done.
        do_conv(27'd7, lat, ob, oo, bs);
        $display("[TB] conv bin=7 lat=%0d bcd=%h ovf=%b", lat, ob, oo);
        tests_run++;
        if (ob !== 32'h0000_0007 || oo !== 1'b0 || lat != 28 || bs !== 1'b1) begin
            tests_failed++;
            $display("FAIL back_to_back: bcd=%h ovf=%b lat=%0d busy=%b required 00000007/0/28/1", ob, oo, lat, bs);
        end
    endtask

    task automatic test_overflow();
        int lat; logic [31:0] ob; logic oo, bs;
        do_conv(27'd100_000_000, lat, ob, oo, bs);
        $display("[TB] conv bin=100000000 lat=%0d bcd=%h ovf=%b", lat, ob, oo);
        tests_run++;
        if (ob !== 32'hFFFF_FFFF || oo !== 1'b1 || lat != 2) begin
            tests_failed++;
            $display("FAIL overflow: bcd=%h ovf=%b lat=%0d required ffffffff/1/2", ob, oo, lat);
        end
        do_conv(27'd42, lat, ob, oo, bs);
        $display("[TB] conv bin=42 lat=%0d bcd=%h ovf=%b", lat, ob, oo);
        tests_run++;
        if (ob !== 32'h0000_0042 || oo !== 1'b0 || lat != 28) begin
            tests_failed++;
            $display("FAIL ovf_clear: bcd=%h ovf=%b lat=%0d required 00000042/0/28", ob, oo, lat);
        end
    endtask

    task automatic test_random();
        int lat; logic [31:0] ob; logic oo, bs;
        int unsigned v;
        for (int i = 0; i < 10; i++) begin
            v = (i % 4 == 3) ? $urandom_range(134_217_727, 100_000_000) : $urandom_range(99_999_999, 0);
            do_conv(27'(v), lat, ob, oo, bs);
            $display("[TB] conv bin=%0d lat=%0d bcd=%h ovf=%b", v, lat, ob, oo);
            tests_run++;
            if (ob !== ref_bcd(v) || oo !== (v > 32'd99_999_999) || lat != ref_lat(v)) begin
                tests_failed++;
                $display("FAIL random_%0d: bin=%0d bcd=%h ovf=%b lat=%0d required %h/%b/%0d",
                         i, v, ob, oo, lat, ref_bcd(v), (v > 32'd99_999_999), ref_lat(v));
            end
        end
    endtask

    task automatic test_ignore_start();
        int unsigned v1, v2;
        int ndone, lat;
        logic [31:0] first_bcd, prev_bcd;
        logic stable;
        v1 = $urandom_range(99_999_999, 0);
        v2 = (v1 + 1234) % 100_000_000;
        ndone = 0; lat = -1; first_bcd = '0; stable = 1'b1;
        prev_bcd = bcd;
        start = 1'b1; bin = 27'(v1);
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            if (c == 10) begin start = 1'b1; bin = 27'(v2); end
            @(posedge clk); #1;
            start = 1'b0;
            if (done) begin
                ndone++;
                if (lat < 0) begin lat = c; first_bcd = bcd; end
            end else if (lat < 0 && bcd !== prev_bcd) begin
                stable = 1'b0;
            end
        end
        $display("[TB] conv bin=%0d (second start bin=%0d) lat=%0d bcd=%h dones=%0d", v1, v2, lat, first_bcd, ndone);
        tests_run++;
        if (ndone != 1 || lat != 28 || first_bcd !== ref_bcd(v1)) begin
            tests_failed++;
            $display("FAIL ignore_start: dones=%0d lat=%0d bcd=%h required 1/28/%h", ndone, lat, first_bcd, ref_bcd(v1));
        end
        tests_run++;
        if (!stable) begin tests_failed++; $display("FAIL bcd_stable: bcd changed before done, required held at %h", prev_bcd); end
    endtask

    task automatic test_reset_abort();
        int lat, ndone; logic [31:0] ob; logic oo, bs;
        do_conv(27'd1234, lat, ob, oo, bs);
        tests_run++;
        if (ob !== 32'h0000_1234) begin tests_failed++; $display("FAIL pre_abort: bcd=%h required 00001234", ob); end
        start = 1'b1; bin = 27'd5678;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        $display("[TB] abort bin=5678 busy=%b done=%b bcd=%h", busy, done, bcd);
        tests_run++;
        if (bcd !== 32'h0 || busy !== 1'b0 || done !== 1'b0 || ovf !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_abort: bcd=%h busy=%b done=%b ovf=%b required 0/0/0/0", bcd, busy, done, ovf);
        end
        ndone = 0;
        for (int c = 0; c < 35; c++) begin
            if (c == 2) begin @(negedge clk); rst = 1'b1; end
            @(posedge clk); #1;
            if (done) ndone++;
        end
        tests_run++;
        if (ndone != 0) begin tests_failed++; $display("FAIL abort_no_done: dones=%0d required 0", ndone); end
        do_conv(27'd5678, lat, ob, oo, bs);
        $display("[TB] conv bin=5678 lat=%0d bcd=%h ovf=%b", lat, ob, oo);
        tests_run++;
        if (ob !== 32'h0000_5678 || oo !== 1'b0 || lat != 28) begin
            tests_failed++;
            $display("FAIL post_abort: bcd=%h ovf=%b lat=%0d required 00005678/0/28", ob, oo, lat);
        end
    endtask

    initial begin
        test_reset();
        test_zero();
        test_known();
        test_back_to_back();
        test_overflow();
        test_random();
        test_ignore_start();
        test_reset_abort();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
